// File: rtl/des_engine_scheduler.sv
// Two-requester front end for a single DES engine: round-robin grant, start pulse,
// bounded wait for completion, and one-cycle result delivery tagged with the requester id.
module des_engine_scheduler #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid_din,
    input  logic [0:63] plaintext_0_din,
    input  logic [0:63] key_0_din,
    input  logic [0:63] plaintext_1_din,
    input  logic [0:63] key_1_din,
    output logic [1:0]  req_ack_dout,
    input  logic        active_des_engine_din,
    input  logic        done_strobe_din,
    input  logic [0:63] ciphertext_din,
    output logic        start_strobe_dout,
    output logic [0:63] plaintext_dout,
    output logic [0:63] key_dout,
    output logic        result_valid_dout,
    output logic        result_id_dout,
    output logic [0:63] ciphertext_dout,
    output logic        timeout_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        BUSY    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    // Compare against the last count so the abort lands on the TIMEOUT_CYCLES-th BUSY cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_reg;
    state_t      state_next;
    logic [7:0]  cnt_reg;
    logic        last_grant_reg;
    logic        grant_id_reg;
    logic [0:63] plaintext_reg;
    logic [0:63] key_reg;
    logic [0:63] ciphertext_reg;
    logic        result_id_reg;

    logic grant_ok;
    logic winner;
    logic done_hit;
    logic timeout_hit;

    // Reset gates the grant so no ack can escape while the block is held in reset.
    assign grant_ok    = !reset && (state_reg == IDLE) && (req_valid_din != 2'b00)
                         && !active_des_engine_din;
    assign winner      = (req_valid_din == 2'b11) ? ~last_grant_reg : req_valid_din[1];
    assign done_hit    = (state_reg == BUSY) && done_strobe_din;
    assign timeout_hit = (state_reg == BUSY) && !done_strobe_din && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_ok) state_next = ISSUE;
            ISSUE:   state_next = BUSY;
            BUSY: begin
                if (done_hit) begin
                    state_next = DELIVER;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            DELIVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ack_dout      = 2'b00;
        start_strobe_dout = 1'b0;
        result_valid_dout = 1'b0;
        timeout_dout      = 1'b0;
        case (state_reg)
            IDLE:    if (grant_ok) req_ack_dout[winner] = 1'b1;
            ISSUE:   start_strobe_dout = 1'b1;
            BUSY:    timeout_dout = timeout_hit;
            DELIVER: result_valid_dout = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= 8'd0;
        end else if (state_reg == ISSUE) begin
            cnt_reg <= 8'd0;
        end else if (state_reg == BUSY) begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

    // last_grant starts at 1 so requester 0 wins the first contention after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
            grant_id_reg   <= 1'b0;
            plaintext_reg  <= '0;
            key_reg        <= '0;
            ciphertext_reg <= '0;
            result_id_reg  <= 1'b0;
        end else begin
            if (grant_ok) begin
                plaintext_reg  <= winner ? plaintext_1_din : plaintext_0_din;
                key_reg        <= winner ? key_1_din : key_0_din;
                grant_id_reg   <= winner;
                last_grant_reg <= winner;
            end
            if (done_hit) begin
                ciphertext_reg <= ciphertext_din;
                result_id_reg  <= grant_id_reg;
            end
        end
    end

    assign plaintext_dout  = plaintext_reg;
    assign key_dout        = key_reg;
    assign ciphertext_dout = ciphertext_reg;
    assign result_id_dout  = result_id_reg;

endmodule

// File: tb/tb_des_engine_scheduler.sv
// Directed bench: one default-timeout instance and one with an 8-cycle timeout share stimulus.
module tb_des_engine_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [0:63] pt0, key0, pt1, key1;
    logic        active;
    logic        done;
    logic [0:63] ct_in;

    logic [1:0]  ack_a, ack_b;
    logic        start_a, start_b;
    logic [0:63] pt_a, pt_b, key_a, key_b, ct_a, ct_b;
    logic        rv_a, rv_b, id_a, id_b, to_a, to_b;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    des_engine_scheduler u_dut_a (
        .clk(clk), .reset(reset), .req_valid_din(req_valid),
        .plaintext_0_din(pt0), .key_0_din(key0),
        .plaintext_1_din(pt1), .key_1_din(key1),
        .req_ack_dout(ack_a), .active_des_engine_din(active),
        .done_strobe_din(done), .ciphertext_din(ct_in),
        .start_strobe_dout(start_a), .plaintext_dout(pt_a), .key_dout(key_a),
        .result_valid_dout(rv_a), .result_id_dout(id_a),
        .ciphertext_dout(ct_a), .timeout_dout(to_a)
    );

    des_engine_scheduler #(.TIMEOUT_CYCLES(8)) u_dut_b (
        .clk(clk), .reset(reset), .req_valid_din(req_valid),
        .plaintext_0_din(pt0), .key_0_din(key0),
        .plaintext_1_din(pt1), .key_1_din(key1),
        .req_ack_dout(ack_b), .active_des_engine_din(active),
        .done_strobe_din(done), .ciphertext_din(ct_in),
        .start_strobe_dout(start_b), .plaintext_dout(pt_b), .key_dout(key_b),
        .result_valid_dout(rv_b), .result_id_dout(id_b),
        .ciphertext_dout(ct_b), .timeout_dout(to_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        active    = 1'b0;
        done      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One full operation: grant cycle, start cycle, engine latency, done, deliver.
    task automatic serve(input bit sel, input logic [1:0] req, input int win,
                         input int lat, input logic [63:0] ct);
        logic [1:0]  onehot;
        logic [63:0] exp_pt, exp_key;
        onehot  = (win != 0) ? 2'b10 : 2'b01;
        exp_pt  = (win != 0) ? pt1 : pt0;
        exp_key = (win != 0) ? key1 : key0;
        tick();
        req_valid = req;
        #1;
        check("ack", sel ? ack_b : ack_a, onehot);
        tick();
        req_valid = req & ~onehot;
        #1;
        check("start", sel ? start_b : start_a, 1);
        check("plaintext", sel ? pt_b : pt_a, exp_pt);
        check("key", sel ? key_b : key_a, exp_key);
        for (int i = 1; i < lat; i++) tick();
        tick();
        done  = 1'b1;
        ct_in = ct;
        #1;
        check("no_early_result", sel ? rv_b : rv_a, 0);
        check("no_timeout_at_done", sel ? to_b : to_a, 0);
        tick();
        done  = 1'b0;
        ct_in = 64'hDEAD_BEEF_0BAD_F00D;
        #1;
        check("result_valid", sel ? rv_b : rv_a, 1);
        check("result_id", sel ? id_b : id_a, win);
        check("ciphertext", sel ? ct_b : ct_a, ct);
        check("no_timeout_deliver", sel ? to_b : to_a, 0);
    endtask

    initial begin
        pt0   = 64'h0123456789ABCDEF;
        key0  = 64'h133457799BBCDFF1;
        pt1   = 64'hFEDCBA9876543210;
        key1  = 64'h0E329232EA6D0D73;
        ct_in = '0;

        // Reset state, with both requests asserted during reset
        reset     = 1'b1;
        req_valid = 2'b11;
        active    = 1'b0;
        done      = 1'b0;
        tick();
        #1;
        check("rst_ack", {ack_a, ack_b}, 0);
        check("rst_pulses", {start_a, rv_a, to_a, start_b, rv_b, to_b}, 0);
        check("rst_regs_a", pt_a | key_a | ct_a, 0);
        check("rst_id", {id_a, id_b}, 0);
        do_reset();

        // Single request, 16-cycle engine
        serve(0, 2'b01, 0, 16, 64'h85E813540F0AB405);
        tick();
        #1;
        check("result_one_cycle", rv_a, 0);
        check("ciphertext_held", ct_a, 64'h85E813540F0AB405);
        check("id_held", id_a, 0);

        // Contention: alternation 0,1,0,1 from reset
        do_reset();
        serve(0, 2'b11, 0, 2, 64'h1111_2222_3333_4444);
        serve(0, 2'b11, 1, 3, 64'h5555_6666_7777_8888);
        serve(0, 2'b11, 0, 2, 64'h9999_AAAA_BBBB_CCCC);
        serve(0, 2'b11, 1, 2, 64'hDDDD_EEEE_FFFF_0000);

        // Engine busy for 5 cycles blocks the grant
        do_reset();
        active = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            req_valid = 2'b01;
            #1;
            check("busy_no_ack", ack_a, 0);
            check("busy_no_start", start_a, 0);
        end
        tick();
        active = 1'b0;
        #1;
        check("busy_then_ack", ack_a, 2'b01);
        tick();
        req_valid = 2'b00;
        #1;
        check("busy_then_start", start_a, 1);

        // Timeout with TIMEOUT_CYCLES=8: abort 8 cycles after start
        do_reset();
        tick();
        req_valid = 2'b01;
        #1;
        check("to_ack", ack_b, 2'b01);
        tick();
        req_valid = 2'b00;
        #1;
        check("to_start", start_b, 1);
        for (int k = 2; k <= 8; k++) begin
            tick();
            check("to_not_yet", to_b, 0);
        end
        tick();
        check("timeout_pulse", to_b, 1);
        check("timeout_no_result", rv_b, 0);
        tick();
        check("timeout_one_cycle", to_b, 0);
        check("timeout_no_result_after", rv_b, 0);
        serve(1, 2'b01, 0, 4, 64'h0F0F_0F0F_F0F0_F0F0);

        // Done on the counter's 8th cycle beats the timeout
        serve(1, 2'b10, 1, 8, 64'hA5A5_5A5A_C3C3_3C3C);

        // Reset while BUSY abandons the operation
        do_reset();
        serve(0, 2'b01, 0, 3, 64'h7777_0000_7777_0000);
        tick();
        req_valid = 2'b01;
        #1;
        check("mid_ack", ack_a, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_regs", pt_a | key_a | ct_a, 0);
        check("mid_rst_pulses", {ack_a, start_a, rv_a, to_a, id_a}, 0);
        tick();
        reset = 1'b0;
        tick();
        done  = 1'b1;
        ct_in = 64'h1234_5678_9ABC_DEF0;
        #1;
        check("stray_done_rv", rv_a, 0);
        tick();
        done = 1'b0;
        #1;
        check("stray_done_rv_next", rv_a, 0);
        check("stray_done_ct", ct_a, 0);
        serve(0, 2'b01, 0, 2, 64'hCAFE_BABE_0000_1111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
